// File: rtl/seg_scan_capture.sv
// seg_scan_capture: snoops a multiplexed active-low 7-segment bus and recovers
// the displayed BCD digits. A digit is sampled once per dwell after the bus
// has settled, and is only published once the same value has been seen on
// several consecutive dwells. Illegal patterns and anode contention are
// flagged with sticky error bits.
module seg_scan_capture #(
    parameter int NUM_DIGITS    = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int STABLE_CNT    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    input  logic                    clr,
    output logic [4*NUM_DIGITS-1:0] bcd_flat,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_done,
    output logic                    err_pattern,
    output logic                    err_anode
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W   = $clog2(SETTLE_CYCLES + 1);
    localparam int MATCH_W = $clog2(STABLE_CNT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PAT_DIGIT = 2'd0,
        PAT_BLANK = 2'd1,
        PAT_BAD   = 2'd2
    } pat_class_t;

    // Synchroniser stages; blank (all-high) is the idle bus value.
    logic [6:0]            seg_s1, seg_s2;
    logic [NUM_DIGITS-1:0] an_s1, an_s2;

    // Dwell tracking.
    state_t             state, state_nxt;
    logic [IDX_W-1:0]   cur_idx, idx_nxt;
    logic [6:0]         ref_seg, ref_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               sample;
    logic               anode_fault;

    // Anode analysis of the synchronised bus.
    logic [NUM_DIGITS-1:0] an_low;
    logic                  any_low, single_low, multi_low;
    logic [IDX_W-1:0]      an_idx;

    // Decode of the dwell's segment pattern.
    logic [6:0]   pat;
    pat_class_t   dec_class;
    logic [3:0]   dec_val;

    // Per-digit capture state.
    logic [NUM_DIGITS-1:0][3:0]         bcd_q;
    logic [NUM_DIGITS-1:0][3:0]         cand_q;
    logic [NUM_DIGITS-1:0][MATCH_W-1:0] match_q;
    logic [NUM_DIGITS-1:0]              mask_q;
    logic [NUM_DIGITS-1:0]              mask_set;

    assign bcd_flat = bcd_q;

    // Two-flop synchroniser for the asynchronous display bus.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every stage
        // samples the pre-edge value of the previous one; blocking here would
        // collapse the two stages into one.
        if (!rst_n) begin
            seg_s1 <= '1;
            seg_s2 <= '1;
            an_s1  <= '1;
            an_s2  <= '1;
        end else begin
            seg_s1 <= seg_n;
            seg_s2 <= seg_s1;
            an_s1  <= an_n;
            an_s2  <= an_s1;
        end
    end

    // Classify the synchronised anode lines and find the selected digit.
    always_comb begin
        an_low     = ~an_s2;
        any_low    = |an_low;
        single_low = $onehot(an_low);
        multi_low  = any_low && !single_low;
        an_idx     = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an_low[i]) an_idx = IDX_W'(i);
        end
    end

    // Dwell FSM state register; clr deliberately leaves it alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cur_idx <= '0;
            ref_seg <= '1;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            cur_idx <= idx_nxt;
            ref_seg <= ref_nxt;
            cnt     <= cnt_nxt;
        end
    end

    // Dwell FSM next state: settle, take exactly one sample, then hold.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        state_nxt   = state;
        idx_nxt     = cur_idx;
        ref_nxt     = ref_seg;
        cnt_nxt     = cnt;
        sample      = 1'b0;
        anode_fault = 1'b0;
        case (state)
            IDLE: begin
                if (single_low) begin
                    state_nxt = SETTLE;
                    idx_nxt   = an_idx;
                    ref_nxt   = seg_s2;
                    cnt_nxt   = '0;
                end else if (multi_low) begin
                    anode_fault = 1'b1;
                end
            end
            SETTLE: begin
                if (!any_low) begin
                    state_nxt = IDLE;
                end else if (multi_low) begin
                    state_nxt   = IDLE;
                    anode_fault = 1'b1;
                end else if (an_idx != cur_idx || seg_s2 != ref_seg) begin
                    idx_nxt = an_idx;
                    ref_nxt = seg_s2;
                    cnt_nxt = '0;
                end else if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    sample    = 1'b1;
                    state_nxt = HOLD;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HOLD: begin
                if (!any_low) begin
                    state_nxt = IDLE;
                end else if (multi_low) begin
                    state_nxt   = IDLE;
                    anode_fault = 1'b1;
                end else if (an_idx != cur_idx) begin
                    state_nxt = SETTLE;
                    idx_nxt   = an_idx;
                    ref_nxt   = seg_s2;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Decode the settled pattern (active-high, bit0=a .. bit6=g).
    always_comb begin
        pat       = ~ref_seg;
        dec_class = PAT_DIGIT;
        dec_val   = 4'd0;
        case (pat)
            7'h3F:   dec_val = 4'd0;
            7'h06:   dec_val = 4'd1;
            7'h5B:   dec_val = 4'd2;
            7'h4F:   dec_val = 4'd3;
            7'h66:   dec_val = 4'd4;
            7'h6D:   dec_val = 4'd5;
            7'h7D:   dec_val = 4'd6;
            7'h07:   dec_val = 4'd7;
            7'h7F:   dec_val = 4'd8;
            7'h6F:   dec_val = 4'd9;
            7'h00:   dec_class = PAT_BLANK;
            default: dec_class = PAT_BAD;
        endcase
    end

    // Sampled-mask including the digit being sampled this cycle.
    always_comb begin
        mask_set          = mask_q;
        mask_set[cur_idx] = 1'b1;
    end

    // Per-digit stability tracking, publishing, frame pulse and error flags.
    always_ff @(posedge clk) begin
        // NOTE: the per-digit register arrays are reset explicitly because
        // clr must return them to a known state; they are flops, not RAM.
        if (!rst_n || clr) begin
            bcd_q       <= '0;
            cand_q      <= '0;
            match_q     <= '0;
            mask_q      <= '0;
            digit_valid <= '0;
            frame_done  <= 1'b0;
            err_pattern <= 1'b0;
            err_anode   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (anode_fault) err_anode <= 1'b1;

            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (match_q[i] == MATCH_W'(STABLE_CNT)) begin
                    bcd_q[i]       <= cand_q[i];
                    digit_valid[i] <= 1'b1;
                end
            end

            if (sample) begin
                if (&mask_set) begin
                    frame_done <= 1'b1;
                    mask_q     <= '0;
                end else begin
                    mask_q <= mask_set;
                end

                case (dec_class)
                    PAT_DIGIT: begin
                        if (dec_val == cand_q[cur_idx]) begin
                            if (match_q[cur_idx] != MATCH_W'(STABLE_CNT))
                                match_q[cur_idx] <= match_q[cur_idx] + MATCH_W'(1);
                        end else begin
                            cand_q[cur_idx]  <= dec_val;
                            match_q[cur_idx] <= MATCH_W'(1);
                        end
                    end
                    PAT_BLANK: begin
                        digit_valid[cur_idx] <= 1'b0;
                        match_q[cur_idx]     <= '0;
                    end
                    default: err_pattern <= 1'b1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: drives multiplexed scans onto the segment bus and
// compares the recovered digits, valid bits, error flags and frame pulses
// against expectations queued alongside each stimulus step.
module tb_seg_scan_capture;

    localparam int ND  = 8;
    localparam int GAP = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            clr;
    logic [6:0]      seg_n;
    logic [ND-1:0]   an_n;
    logic [4*ND-1:0] bcd_flat;
    logic [ND-1:0]   digit_valid;
    logic            frame_done;
    logic            err_pattern;
    logic            err_anode;

    seg_scan_capture #(
        .NUM_DIGITS    (ND),
        .SETTLE_CYCLES (4),
        .STABLE_CNT    (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .clr         (clr),
        .bcd_flat    (bcd_flat),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .err_pattern (err_pattern),
        .err_anode   (err_anode)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] bcd;
        logic [7:0]  valid;
        logic        ep;
        logic        ea;
        int          frames;
    } exp_t;

    typedef struct {
        int         idx;
        logic [6:0] p;
        int         cyc;
        exp_t       exp;
    } vec_t;

    int         total     = 0;
    int         bad       = 0;
    int         frame_cnt = 0;
    exp_t       exp_q[$];
    vec_t       vecs[$];
    logic [6:0] seg_of [10];
    int         val [8];

    // Count cycles with frame_done high.
    always @(negedge clk) begin
        if (frame_done === 1'b1) frame_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Hold one digit on the bus, then blank it so the next dwell starts fresh.
    task automatic show(input int idx, input logic [6:0] p, input int cyc);
        an_n  = ~(8'b1 << idx);
        seg_n = ~p;
        tick(cyc);
        an_n  = '1;
        seg_n = '1;
        tick(GAP);
    endtask

    task automatic push_exp(input string name, input logic [31:0] b, input logic [7:0] v,
                            input logic ep, input logic ea, input int fr);
        exp_t e;
        e.name = name; e.bcd = b; e.valid = v; e.ep = ep; e.ea = ea; e.frames = fr;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: queue empty");
            return;
        end
        e = exp_q.pop_front();
        check({e.name, ".bcd"},    bcd_flat, e.bcd);
        check({e.name, ".valid"},  {24'b0, digit_valid}, {24'b0, e.valid});
        check({e.name, ".err_pat"}, {31'b0, err_pattern}, {31'b0, e.ep});
        check({e.name, ".err_an"},  {31'b0, err_anode}, {31'b0, e.ea});
        check({e.name, ".frames"},  frame_cnt, e.frames);
    endtask

    initial begin
        logic [31:0] eb;
        logic [7:0]  ev;
        vec_t        v;

        seg_of = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        val    = '{2, 0, 2, 4, 1, 2, 3, 1};

        // Three scans: first arms candidates, second publishes, third has a
        // bad pattern on digit 3.
        eb = '0;
        ev = '0;
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < ND; i++) begin
                v.idx = i;
                v.p   = (s == 2 && i == 3) ? 7'h55 : seg_of[val[i]];
                v.cyc = 8;
                if (s == 1) begin
                    eb[4*i +: 4] = 4'(val[i]);
                    ev[i]        = 1'b1;
                end
                v.exp.name   = $sformatf("scan%0d_d%0d", s + 1, i);
                v.exp.bcd    = eb;
                v.exp.valid  = ev;
                v.exp.ep     = (s == 2 && i >= 3);
                v.exp.ea     = 1'b0;
                v.exp.frames = s + ((i == ND - 1) ? 1 : 0);
                vecs.push_back(v);
            end
        end

        // Reset with garbage on the bus.
        rst_n = 1'b0;
        clr   = 1'b0;
        an_n  = 8'b0101_0011;
        seg_n = 7'h2A;
        tick(3);
        push_exp("reset", 32'h0, 8'h00, 1'b0, 1'b0, 0);
        pop_cmp();
        an_n  = '1;
        seg_n = '1;
        rst_n = 1'b1;
        tick(4);
        push_exp("post_reset", 32'h0, 8'h00, 1'b0, 1'b0, 0);
        pop_cmp();

        foreach (vecs[k]) begin
            exp_q.push_back(vecs[k].exp);
            show(vecs[k].idx, vecs[k].p, vecs[k].cyc);
            pop_cmp();
        end

        // Two anodes low together: contention flagged, nothing sampled.
        push_exp("anode_clash", 32'h13214202, 8'hFF, 1'b1, 1'b1, 3);
        an_n  = 8'b1111_1100;
        seg_n = ~seg_of[5];
        tick(8);
        an_n  = '1;
        seg_n = '1;
        tick(GAP);
        pop_cmp();

        // Short dwell on digit 5 must not sample, so no frame completes.
        push_exp("short_dwell", 32'h13214202, 8'hFF, 1'b1, 1'b1, 3);
        for (int i = 0; i < ND; i++) show(i, seg_of[val[i]], (i == 5) ? 3 : 8);
        pop_cmp();
        push_exp("digit5_full", 32'h13214202, 8'hFF, 1'b1, 1'b1, 4);
        show(5, seg_of[val[5]], 8);
        pop_cmp();

        // A single dwell of a new value is not enough; two in a row is.
        push_exp("d1_seven_once", 32'h13214202, 8'hFF, 1'b1, 1'b1, 4);
        show(1, seg_of[7], 8);
        pop_cmp();
        push_exp("d1_back_zero", 32'h13214202, 8'hFF, 1'b1, 1'b1, 4);
        show(1, seg_of[0], 8);
        pop_cmp();
        push_exp("d1_seven_a", 32'h13214202, 8'hFF, 1'b1, 1'b1, 4);
        show(1, seg_of[7], 8);
        pop_cmp();
        push_exp("d1_seven_b", 32'h13214272, 8'hFF, 1'b1, 1'b1, 4);
        show(1, seg_of[7], 8);
        pop_cmp();

        // clr wipes outputs, errors and candidate history.
        push_exp("clr", 32'h0, 8'h00, 1'b0, 1'b0, 4);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        pop_cmp();
        push_exp("after_clr_once", 32'h0, 8'h00, 1'b0, 1'b0, 4);
        show(0, seg_of[9], 8);
        pop_cmp();
        push_exp("after_clr_twice", 32'h9, 8'h01, 1'b0, 1'b0, 4);
        show(0, seg_of[9], 8);
        pop_cmp();

        // A blank sample drops the valid bit but keeps the value.
        push_exp("blank_digit0", 32'h9, 8'h00, 1'b0, 1'b0, 4);
        show(0, 7'h00, 8);
        pop_cmp();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
